alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller that sits in front of the 32-bit ALU (registered output, 1-cycle latency, 1-bit shift only when its shamt input is 1).
- Accepts one operation per start handshake and issues it to the ALU.
- Shifts of any amount from 0 to 31 are performed as repeated 1-bit ALU passes, with the result fed back each pass.
- REL is resolved locally. Each operation returns a result, signed status flags, and a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width; legal shift counts are 0..2^SHAMT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE
func  input  4  opcode: ADD 0000, SUB 0001, REL 0010, SLA 0011, SRL 0100, AND 0101, NOT 0110, OR 0111, XOR 1000, SRA 1001
shamt  input  SHAMT_W  shift count; used only for SLA/SRL/SRA
in1  input  WIDTH  operand 1
in2  input  WIDTH  operand 2
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when result, flags and err are valid
result  output  WIDTH  operation result; held until the next accepted start
flags  output  3  [2] zero, [1] signed positive, [0] signed negative; derived from result
err  output  1  unsupported opcode; valid with done
alu_in1  output  WIDTH  ALU operand 1; equals the accumulator register acc
alu_in2  output  WIDTH  ALU operand 2; equals captured in2
alu_func  output  4  captured func
alu_shamt  output  SHAMT_W  1 for shift ops, 0 otherwise
alu_out  input  WIDTH  ALU registered output

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy, done, err, result, flags, acc, count, captured operands all cleared to 0.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, start=1: capture func, in2, shamt; acc<=in1. Next state:
  - Opcodes 1010-1111: DONE with result=0, err=1, flags=100.
  - REL: DONE with result=in1 and flags computed locally.
  - Shift with shamt=0: DONE with result=in1.
  - Shift with shamt>0: count<=shamt, go to ISSUE.
  - Any other opcode: count<=1, go to ISSUE.
- ISSUE (1 cycle): ALU samples alu_in1/alu_in2/alu_func/alu_shamt on the closing edge; go to WAIT.
- WAIT (1 cycle): alu_out is valid. On the closing edge acc<=alu_out, count<=count-1. If count-1==0, go to DONE with result<=alu_out; else go to ISSUE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- Start handling: start is ignored in every state except IDLE, including DONE. The earliest back-to-back start is the cycle after done.
- Latency, counting the start-accept cycle as cycle 0:
  - done in cycle 1 for REL, shamt=0 shifts and illegal opcodes.
  - done in cycle 3 for single-pass ops.
  - done in cycle 1+2N for an N-bit shift; worst case N=31 gives cycle 63.
- alu_out is never sampled outside WAIT, so stale ALU output, or the ALU's own sync reset, does not affect results.
- Arithmetic: wrap-around modulo 2^WIDTH, no carry/overflow output. The SLA/SRL/SRA bit semantics are the ALU's.
- Flags:
  - Evaluated on the final result, signed two's complement.
  - Exactly one bit set: zero=100, positive=010, negative=001.
  - Updated only at the transition into DONE.
- Captured operands are stable for the whole operation; changes on the in1/in2/func/shamt ports after acceptance are ignored.

Test Plan:
- Reset sequencing: assert rst=0 mid-shift (SLA, shamt=20, at cycle 9) -> busy=0, result=0, flags=000 immediately; no done pulse; after release, a new ADD 2+3 completes normally with result=5.
- ADD: in1=0x7FFFFFFF, in2=1 -> done in cycle 3, result=0x80000000, flags=001, err=0. SUB: in1=5, in2=5 -> result=0, flags=100.
- SLA: in1=0x00000001, shamt=4 -> exactly 4 ALU issues with alu_shamt=1, done in cycle 9, result=0x00000010, flags=010.
- SRA: in1=0x80000000, shamt=3 -> result=0xF0000000, flags=001, done in cycle 7. SRL: in1=0xFFFFFFFF, shamt=31 -> result=0x00000001, done in cycle 63.
- REL: in1=0xFFFFFFFE -> done in cycle 1, flags=001, result=0xFFFFFFFE, no ALU issue. Shift with shamt=0 -> done in cycle 1, result=in1.
- Handshake: start held high through the whole operation -> only one operation executes and the second starts in the cycle after done. func=1100 -> done in cycle 1, err=1, result=0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Bundles the request/response handshake and the ALU-side bus of alu_op_sequencer.
// master drives requests and the ALU result; slave is the sequencer itself.
interface alu_op_sequencer_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [3:0]         func;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic [2:0]         flags;
   logic               err;
   logic [WIDTH-1:0]   alu_in1;
   logic [WIDTH-1:0]   alu_in2;
   logic [3:0]         alu_func;
   logic [SHAMT_W-1:0] alu_shamt;
   logic [WIDTH-1:0]   alu_out;

   modport master (
      output start, func, shamt, in1, in2, alu_out,
      input  busy, done, result, flags, err, alu_in1, alu_in2, alu_func, alu_shamt
   );

   modport slave (
      input  start, func, shamt, in1, in2, alu_out,
      output busy, done, result, flags, err, alu_in1, alu_in2, alu_func, alu_shamt
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one operation per start to a registered 1-bit-shift ALU; multi-bit shifts
// are looped through the ALU, REL/zero shifts/illegal opcodes are resolved locally.
module alu_op_sequencer #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus
);

   localparam logic [3:0] OP_REL = 4'b0010;
   localparam logic [3:0] OP_SLA = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_MAX = 4'b1001;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [3:0]         func_q;
   logic [WIDTH-1:0]   in2_q;
   logic [WIDTH-1:0]   acc_q;
   logic [SHAMT_W-1:0] count_q;
   logic [WIDTH-1:0]   result_q;
   logic [2:0]         flags_q;
   logic               err_q;
   logic               local_done;
   logic               last_pass;

   function automatic logic is_shift(input logic [3:0] f);
      return (f == OP_SLA) || (f == OP_SRL) || (f == OP_SRA);
   endfunction

   function automatic logic is_illegal(input logic [3:0] f);
      return f > OP_MAX;
   endfunction

   function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] v);
      if (v == '0)           return 3'b100;
      else if (v[WIDTH-1])   return 3'b001;
      else                   return 3'b010;
   endfunction

   // Operations that finish without touching the ALU go straight to DONE.
   assign local_done = is_illegal(bus.func) || (bus.func == OP_REL) ||
                       (is_shift(bus.func) && (bus.shamt == '0));
   assign last_pass  = (count_q == SHAMT_W'(1));

   // NOTE: non-blocking assignments in clocked blocks so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: default assigned first so no path through the case leaves state_d
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = local_done ? DONE : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = last_pass ? DONE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         func_q   <= '0;
         in2_q    <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  func_q <= bus.func;
                  in2_q  <= bus.in2;
                  acc_q  <= bus.in1;
                  if (is_illegal(bus.func)) begin
                     result_q <= '0;
                     flags_q  <= 3'b100;
                     err_q    <= 1'b1;
                  end else if (local_done) begin
                     result_q <= bus.in1;
                     flags_q  <= flags_of(bus.in1);
                     err_q    <= 1'b0;
                  end else begin
                     count_q <= is_shift(bus.func) ? bus.shamt : SHAMT_W'(1);
                  end
               end
            end
            WAIT: begin
               // alu_out is only trusted here, one cycle after the operands were issued.
               acc_q   <= bus.alu_out;
               count_q <= count_q - SHAMT_W'(1);
               if (last_pass) begin
                  result_q <= bus.alu_out;
                  flags_q  <= flags_of(bus.alu_out);
                  err_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.err       = err_q;
   assign bus.alu_in1   = acc_q;
   assign bus.alu_in2   = in2_q;
   assign bus.alu_func  = func_q;
   assign bus.alu_shamt = SHAMT_W'(is_shift(func_q));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural registered 1-bit-shift ALU.
module tb_alu_op_sequencer;
   localparam int W = 32;
   localparam int S = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.WIDTH(W), .SHAMT_W(S)) bus ();

   alu_op_sequencer #(.WIDTH(W), .SHAMT_W(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b,
                                          input logic [3:0] f, input logic [S-1:0] sh);
      case (f)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h3:    return (sh == 1) ? (a << 1) : a;
         4'h4:    return (sh == 1) ? (a >> 1) : a;
         4'h5:    return a & b;
         4'h6:    return ~a;
         4'h7:    return a | b;
         4'h8:    return a ^ b;
         4'h9:    return (sh == 1) ? W'($signed(a) >>> 1) : a;
         default: return '0;
      endcase
   endfunction

   always @(posedge clk)
      bus.alu_out <= alu_f(bus.alu_in1, bus.alu_in2, bus.alu_func, bus.alu_shamt);

   int vectors     = 0;
   int miscompares = 0;
   int lat, passes, done_seen;
   bit sh_ok;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] f, input logic [S-1:0] sh,
                        input logic [W-1:0] a, b, input bit hold);
      @(negedge clk);
      bus.func  = f;
      bus.shamt = sh;
      bus.in1   = a;
      bus.in2   = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
   endtask

   // Returns done latency (cycle after accept = 1) and busy-not-done cycle count.
   task automatic wait_done(input bit hold, input bit exp_shift,
                            output int l, output int p, output bit ok);
      l = -1; p = 0; ok = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.done) begin
            l = i;
            break;
         end
         if (bus.busy) begin
            p++;
            if (bus.alu_shamt !== S'(exp_shift)) ok = 1'b0;
         end
         if (hold) begin
            bus.in1   = $urandom;
            bus.in2   = $urandom;
            bus.shamt = S'($urandom);
         end
      end
   endtask

   task automatic run(input string tag, input logic [3:0] f, input logic [S-1:0] sh,
                      input logic [W-1:0] a, b, input logic [W-1:0] exp_res,
                      input logic [2:0] exp_flags, input logic exp_err,
                      input int exp_lat, input int exp_issues);
      bit shift_op;
      shift_op = (f == 4'h3) || (f == 4'h4) || (f == 4'h9);
      issue(f, sh, a, b, 1'b0);
      wait_done(1'b0, shift_op, lat, passes, sh_ok);
      check({tag, ".latency"}, W'(lat), W'(exp_lat));
      check({tag, ".result"}, bus.result, exp_res);
      check({tag, ".flags"}, W'(bus.flags), W'(exp_flags));
      check({tag, ".err"}, W'(bus.err), W'(exp_err));
      check({tag, ".issues"}, W'(passes / 2), W'(exp_issues));
      check({tag, ".alu_shamt"}, W'(sh_ok), W'(1));
   endtask

   initial begin
      bus.start = 1'b0;
      bus.func  = '0;
      bus.shamt = '0;
      bus.in1   = '0;
      bus.in2   = '0;

      #12;
      check("reset.busy", W'(bus.busy), 0);
      check("reset.done", W'(bus.done), 0);
      check("reset.result", bus.result, 0);
      check("reset.flags", W'(bus.flags), 0);
      check("reset.err", W'(bus.err), 0);
      check("reset.alu_in1", bus.alu_in1, 0);
      @(negedge clk);
      rst = 1'b1;

      run("add_ovf", 4'h0, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b001, 1'b0, 3, 1);
      run("sub_zero", 4'h1, 5'd0, 32'd5, 32'd5, 32'h0, 3'b100, 1'b0, 3, 1);

      repeat (3) @(negedge clk);
      bus.in1 = 32'hDEAD_BEEF;
      check("result_held", bus.result, 32'h0);

      run("sla4", 4'h3, 5'd4, 32'h1, 32'h0, 32'h10, 3'b010, 1'b0, 9, 4);
      run("sra3", 4'h9, 5'd3, 32'h8000_0000, 32'h0, 32'hF000_0000, 3'b001, 1'b0, 7, 3);
      run("srl31", 4'h4, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h1, 3'b010, 1'b0, 63, 31);
      run("rel", 4'h2, 5'd7, 32'hFFFF_FFFE, 32'h5, 32'hFFFF_FFFE, 3'b001, 1'b0, 1, 0);
      run("sla0", 4'h3, 5'd0, 32'h0000_1234, 32'h0, 32'h0000_1234, 3'b010, 1'b0, 1, 0);
      run("illegal", 4'hC, 5'd3, 32'h1111_1111, 32'h2, 32'h0, 3'b100, 1'b1, 1, 0);
      run("and", 4'h5, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b001, 1'b0, 3, 1);
      run("xor", 4'h8, 5'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 3'b010, 1'b0, 3, 1);
      run("not", 4'h6, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b100, 1'b0, 3, 1);
      run("or", 4'h7, 5'd0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 3'b010, 1'b0, 3, 1);

      // start held high: inputs scrambled after accept must not disturb the operation
      issue(4'h0, 5'd0, 32'd2, 32'd3, 1'b1);
      wait_done(1'b1, 1'b0, lat, passes, sh_ok);
      check("hold1.latency", W'(lat), 3);
      check("hold1.result", bus.result, 32'd5);
      bus.func  = 4'h1;
      bus.shamt = '0;
      bus.in1   = 32'd10;
      bus.in2   = 32'd3;
      @(negedge clk);
      check("hold.idle_busy", W'(bus.busy), 0);
      check("hold.idle_done", W'(bus.done), 0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(1'b0, 1'b0, lat, passes, sh_ok);
      check("hold2.latency", W'(lat), 3);
      check("hold2.result", bus.result, 32'd7);
      check("hold2.flags", W'(bus.flags), 3'b010);

      // reset in the middle of a 20-bit shift
      issue(4'h3, 5'd20, 32'h1, 32'h0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst.busy", W'(bus.busy), 0);
      check("midrst.done", W'(bus.done), 0);
      check("midrst.result", bus.result, 0);
      check("midrst.flags", W'(bus.flags), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_seen++;
      end
      check("midrst.no_done", W'(done_seen), 0);
      run("post_rst_add", 4'h0, 5'd0, 32'd2, 32'd3, 32'd5, 3'b010, 1'b0, 3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
